// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: dbus responder backed by a word-addressed 64-bit memory with fixed response latency and a backdoor load port
package dbus_pkg;
    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_mem_responder
    import dbus_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  dbus_req_t                    dreq,
    output dbus_resp_t                   dresp,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_idx,
    input  logic [63:0]                  bd_wdata,
    output logic                         bus_err,
    output logic [31:0]                  txn_count
);
    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [63:0] SPAN = 64'(MEM_WORDS) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx;
    logic [7:0]    strobe;
    logic [63:0]   wdata;
    logic          in_range;
    logic [63:0]   mem [MEM_WORDS];
    logic [63:0]   off;
    logic          hit;
    logic          bus_wr;
    logic          unused_size;

    // size only matters to the requester, which extracts bytes from the full word
    assign unused_size = ^dreq.size;
    assign off    = dreq.addr - BASE_ADDR;
    assign hit    = (dreq.addr >= BASE_ADDR) && (off < SPAN);
    assign bus_wr = (state == RESP) && in_range && !reset;

    // Handshake FSM: latch the request on acceptance, count down the latency, respond for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: if (dreq.valid) begin
                    idx      <= off[3 +: AW];
                    strobe   <= dreq.strobe;
                    wdata    <= dreq.data;
                    in_range <= hit;
                    cnt      <= 4'(LATENCY - 1);
                    state    <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd1) ? RESP : WAIT;
                end
                RESP: begin
                    state     <= IDLE;
                    txn_count <= txn_count + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory update: backdoor first so a same-word bus write overrides it on strobed lanes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bd_we) mem[bd_idx][8*i +: 8] <= bd_wdata[8*i +: 8];
            if (bus_wr && strobe[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Response decode: data only in RESP, zero for out-of-range reads
    always_comb begin
        dresp.addr_ok = (state == RESP);
        dresp.data_ok = (state == RESP);
        dresp.data    = ((state == RESP) && in_range) ? mem[idx] : '0;
        bus_err       = (state == RESP) && !in_range;
    end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb_dbus_mem_responder: directed checks of the dbus memory responder at latencies 1, 2 and 4
module tb_dbus_mem_responder;
    import dbus_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 0;
    logic rst1, rst2, rst4;
    logic v1, v2, v4;
    logic [63:0] ra, rd;
    logic [7:0]  rs;
    logic        bd_we;
    logic [11:0] bd_idx;
    logic [63:0] bd_wdata;
    dbus_req_t   q1, q2, q4;
    dbus_resp_t  p1, p2, p4;
    logic        e1, e2, e4;
    logic [31:0] n1, n2, n4;
    int passes = 0;
    int total = 0;

    always #5 clk = ~clk;

    always_comb begin
        q1 = '{valid: v1, addr: ra, size: MSIZE8, strobe: rs, data: rd};
        q2 = '{valid: v2, addr: ra, size: MSIZE8, strobe: rs, data: rd};
        q4 = '{valid: v4, addr: ra, size: MSIZE8, strobe: rs, data: rd};
    end

    dbus_mem_responder #(.LATENCY(1)) u1 (.clk(clk), .reset(rst1), .dreq(q1), .dresp(p1), .bd_we(bd_we),
        .bd_idx(bd_idx), .bd_wdata(bd_wdata), .bus_err(e1), .txn_count(n1));
    dbus_mem_responder #(.LATENCY(2)) u2 (.clk(clk), .reset(rst2), .dreq(q2), .dresp(p2), .bd_we(bd_we),
        .bd_idx(bd_idx), .bd_wdata(bd_wdata), .bus_err(e2), .txn_count(n2));
    dbus_mem_responder #(.LATENCY(4)) u4 (.clk(clk), .reset(rst4), .dreq(q4), .dresp(p4), .bd_we(bd_we),
        .bd_idx(bd_idx), .bd_wdata(bd_wdata), .bus_err(e4), .txn_count(n4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bd(input logic [11:0] i, input logic [63:0] d);
        bd_we = 1; bd_idx = i; bd_wdata = d;
        tick(1);
        bd_we = 0;
    endtask

    task automatic req(input int dut, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        ra = a; rs = s; rd = d;
        v1 = (dut == 1); v2 = (dut == 2); v4 = (dut == 4);
    endtask

    task automatic idle();
        v1 = 0; v2 = 0; v4 = 0;
    endtask

    logic [63:0] walk_addr [3];
    logic [63:0] walk_pte  [3];

    initial begin
        rst1 = 1; rst2 = 1; rst4 = 1;
        idle(); ra = '0; rs = '0; rd = '0;
        bd_we = 0; bd_idx = '0; bd_wdata = '0;
        walk_addr[0] = BASE + 64'h1008; walk_pte[0] = 64'h2000_0801;
        walk_addr[1] = BASE + 64'h2010; walk_pte[1] = 64'h2000_0C01;
        walk_addr[2] = BASE + 64'h3018; walk_pte[2] = 64'h2000_40CF;
        tick(1);
        // preload while all responders are held in reset
        bd(12'd5,     64'hDEAD_BEEF_0000_1111);
        bd(12'd2,     64'hFFFF_FFFF_FFFF_FFFF);
        bd(12'd0,     64'h0123_4567_89AB_CDEF);
        bd(12'd4095,  64'hFEDC_BA98_7654_3210);
        bd(12'd3,     64'h3333_3333_3333_3333);
        bd(12'd6,     64'h0);
        bd(12'h201,   walk_pte[0]);
        bd(12'h402,   walk_pte[1]);
        bd(12'h603,   walk_pte[2]);
        rst1 = 0; rst2 = 0; rst4 = 0;
        chk("reset resp u2", p2, '0);
        chk("reset err u2", e2, 0);
        chk("reset txn u2", n2, 0);
        chk("reset resp u1", p1, '0);
        chk("reset txn u4", n4, 0);

        // read latency 2
        req(2, BASE + 64'h28, 8'h00, 64'h0);
        chk("lat t", p2.data_ok, 0);
        tick(1);
        chk("lat t+1", {p2.addr_ok, p2.data_ok}, 2'b00);
        tick(1);
        chk("lat t+2 ok", {p2.addr_ok, p2.data_ok}, 2'b11);
        chk("lat t+2 data", p2.data, 64'hDEAD_BEEF_0000_1111);
        chk("lat t+2 err", e2, 0);
        idle();
        tick(1);
        chk("lat t+3 ok", {p2.addr_ok, p2.data_ok}, 2'b00);
        chk("lat t+3 data", p2.data, 0);
        chk("lat txn", n2, 1);

        // strobed write over all-ones word, then read back
        req(2, BASE + 64'h10, 8'h0F, 64'h1122_3344_5566_7788);
        tick(2);
        chk("wr ok", p2.data_ok, 1);
        chk("wr old data", p2.data, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        tick(1);
        req(2, BASE + 64'h10, 8'h00, 64'h0);
        tick(2);
        chk("wr readback", p2.data, 64'hFFFF_FFFF_5566_7788);
        idle();
        tick(1);
        chk("wr txn", n2, 3);

        // bus write and backdoor write to the same word in the same cycle
        req(2, BASE + 64'h30, 8'h0F, 64'h1111_1111_2222_2222);
        tick(2);
        chk("coll ok", p2.data_ok, 1);
        bd_we = 1; bd_idx = 12'd6; bd_wdata = 64'h9999_9999_9999_9999;
        idle();
        tick(1);
        bd_we = 0;
        req(2, BASE + 64'h30, 8'h00, 64'h0);
        tick(2);
        chk("coll merge", p2.data, 64'h9999_9999_2222_2222);
        idle();
        tick(1);

        // back-to-back reads with valid held, latency 1
        req(1, BASE + 64'h28, 8'h00, 64'h0);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk($sformatf("b2b t+%0d", k), p1.data_ok, 64'(k % 2));
            if (k % 2 == 1) chk($sformatf("b2b data t+%0d", k), p1.data, 64'hDEAD_BEEF_0000_1111);
        end
        idle();
        tick(1);
        chk("b2b txn", n1, 3);

        // out-of-range accesses
        req(1, BASE - 64'h8, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0);
        tick(1);
        chk("oor wr ok", p1.data_ok, 1);
        chk("oor wr err", e1, 1);
        idle();
        tick(1);
        chk("oor err pulse end", e1, 0);
        req(1, BASE + 64'h8000, 8'hFF, 64'hBAD1_BAD1_BAD1_BAD1);
        tick(1);
        chk("oor wr2 err", e1, 1);
        idle();
        tick(1);
        req(1, BASE + 64'h8000, 8'h00, 64'h0);
        tick(1);
        chk("oor rd ok", p1.data_ok, 1);
        chk("oor rd err", e1, 1);
        chk("oor rd data", p1.data, 0);
        idle();
        tick(1);
        req(1, BASE, 8'h00, 64'h0);
        tick(1);
        chk("mem0 kept", p1.data, 64'h0123_4567_89AB_CDEF);
        chk("in-range no err", e1, 0);
        idle();
        tick(1);
        req(1, BASE + 64'h7FF8, 8'h00, 64'h0);
        tick(1);
        chk("memlast kept", p1.data, 64'hFEDC_BA98_7654_3210);
        idle();
        tick(1);
        chk("oor txn", n1, 8);

        // Sv39 page walk, latency 4
        for (int l = 0; l < 3; l++) begin
            req(4, walk_addr[l], 8'h00, 64'h0);
            tick(3);
            chk($sformatf("walk%0d t+3", l), p4.data_ok, 0);
            tick(1);
            chk($sformatf("walk%0d ok", l), p4.data_ok, 1);
            chk($sformatf("walk%0d pte", l), p4.data, walk_pte[l]);
            idle();
            tick(1);
        end
        chk("walk txn", n4, 3);

        // reset in the middle of a write
        req(4, BASE + 64'h18, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        tick(2);
        chk("mid t+2", p4.data_ok, 0);
        rst4 = 1;
        idle();
        tick(1);
        rst4 = 0;
        chk("mid t+3", p4.data_ok, 0);
        chk("mid txn", n4, 0);
        tick(1);
        chk("mid t+4", p4.data_ok, 0);
        tick(1);
        chk("mid t+5", p4.data_ok, 0);
        req(4, BASE + 64'h18, 8'h00, 64'h0);
        tick(4);
        chk("post rst ok", p4.data_ok, 1);
        chk("post rst data", p4.data, 64'h3333_3333_3333_3333);
        idle();
        tick(1);
        chk("post rst txn", n4, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Responder (slave) end of the dbus request/response protocol: accepts dbus_req_t, answers with dbus_resp_t (addr_ok, data_ok, data).
- Backs a word-addressed 64-bit memory array with a configurable fixed response latency.
- Serves as the memory model behind cbus for page-table walks and translated accesses, so the address-translation unit can be verified in isolation.
- Also has a backdoor load port so benches can preload page tables and data.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words; must be a power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from acceptance to data_ok; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dreq  in  dbus_req_t  fields: valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]
- dresp  out  dbus_resp_t  fields: addr_ok, data_ok, data[63:0]
- bd_we  in  1  backdoor word write enable
- bd_idx  in  $clog2(MEM_WORDS)  backdoor word index
- bd_wdata  in  64  backdoor write data
- bus_err  out  1  one-cycle pulse: out-of-range access completed
- txn_count  out  32  completed transactions counter

Behaviour:
- Reset values:
  - All outputs 0; FSM goes to IDLE; latency counter 0.
  - Memory array is NOT cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dreq.valid=1, latch addr, strobe, data; load cnt=LATENCY-1.
  - If LATENCY=1 go to RESP, otherwise go to WAIT.
- WAIT: cnt decrements each cycle; when cnt reaches 1, go to RESP.
- RESP:
  - dresp.addr_ok=1 and dresp.data_ok=1 for exactly one cycle, then go to IDLE.
  - Net timing: valid first seen in IDLE at cycle t gives data_ok at cycle t+LATENCY.
- Handshake rules:
  - Requester holds valid and all fields stable from assertion through the data_ok cycle.
  - Responder uses only the fields latched at acceptance.
  - After data_ok, at least one IDLE cycle follows. If valid is still high in that IDLE cycle, it starts a new transaction.
- Address decode:
  - off = addr - BASE_ADDR; idx = off[3+$clog2(MEM_WORDS)-1:3]; addr[2:0] is ignored for indexing.
  - In range iff addr >= BASE_ADDR and off < MEM_WORDS*8.
- Read:
  - dresp.data = full 64-bit word mem[idx], read combinationally in RESP.
  - size does not mask read data; the requester extracts bytes.
- Write:
  - Byte lane i of mem[idx] is updated with data[8i+7:8i] when strobe[i]=1.
  - Update happens at the clock edge ending the RESP cycle.
  - strobe=0 means a read.
- Out-of-range access:
  - Reads return 0; writes are dropped.
  - Handshake completes normally, and bus_err pulses in the RESP cycle.
- dresp.data is 0 outside RESP.
- txn_count increments by 1 at the end of every RESP cycle; wraps at 2^32.
- Backdoor port:
  - bd_we writes mem[bd_idx] at the clock edge, in any state.
  - If the bus write and the backdoor write hit the same word in the same cycle, the bus write wins per strobed byte lane; unstrobed lanes take bd_wdata.
  - Backdoor writes are also accepted during reset.
- Reset mid-transaction: FSM returns to IDLE, the pending write is discarded, data_ok is not asserted, txn_count is cleared to 0.

Test Plan:
- Read latency: LATENCY=2; backdoor mem[5]=64'hDEAD_BEEF_0000_1111; valid at cycle t with addr=BASE+0x28 -> at t+2, addr_ok=data_ok=1 and data=64'hDEAD_BEEF_0000_1111; both low at t+1 and t+3.
- Strobed write: write addr=BASE+0x10, strobe=8'h0F, data=64'h1122_3344_5566_7788 over mem[2]=64'hFFFF_FFFF_FFFF_FFFF -> subsequent read returns 64'hFFFF_FFFF_5566_7788; txn_count=2.
- Back-to-back: valid held high across 3 reads with LATENCY=1 -> data_ok at t+1, t+3, t+5; txn_count=3.
- Out-of-range: write addr=BASE-8, then read addr=BASE+MEM_WORDS*8 -> both complete; bus_err pulses twice; read data=0; mem[0] and mem[MEM_WORDS-1] unchanged.
- Reset mid-transaction: LATENCY=4; write accepted at t, reset at t+2 -> no data_ok is ever asserted; target word unchanged; txn_count=0; new read after reset completes normally.
- Page-walk pattern: preload 3-level Sv39 PTEs via backdoor; issue three 8-byte reads at the walk addresses -> each returns the preloaded PTE after LATENCY cycles, with size=MSIZE8 and strobe=0.
